// File: rtl/pong_pkg.sv
// Shared encodings for the paddle game: match states, winner codes and
// score width. Used by the sequencer, the ball logic and the LED/SSD drivers.
package pong_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Sequencer <-> ball logic link: frame tick and miss pulses come in,
// ball motion enable and serve launch go out.
interface pong_game_ctrl_if;

  logic tick;
  logic p1_miss;
  logic p2_miss;
  logic ball_run;
  logic serve;
  logic serve_dir;

  // Game sequencer side.
  modport master (
    input  tick, p1_miss, p2_miss,
    output ball_run, serve, serve_dir
  );

  // Ball/paddle logic side.
  modport slave (
    output tick, p1_miss, p2_miss,
    input  ball_run, serve, serve_dir
  );

endinterface

// File: rtl/pong_game_ctrl_start_sync.sv
// Two-flop synchronizer with rising-edge detect for a slow switch/button.
// The edge register only starts following the synchronized level once the
// pipeline holds a real input sample, so a switch already high when reset
// releases is not mistaken for a fresh press.
module start_sync (
  input  logic board_clk,
  input  logic reset,
  input  logic in_async,
  output logic start_s,
  output logic start_rise
);

  logic meta;
  logic prev;
  logic valid1;
  logic valid2;

  // Synchronizer pipeline, fill tracking and edge register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b0;
      start_s <= 1'b0;
      prev    <= 1'b1;
      valid1  <= 1'b0;
      valid2  <= 1'b0;
    end else begin
      meta    <= in_async;
      start_s <= meta;
      valid1  <= 1'b1;
      valid2  <= valid1;
      if (valid2) begin
        prev <= start_s;
      end
    end
  end

  assign start_rise = valid2 & start_s & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer: idle / player-1 serve round / player-2 serve round / done.
// Times the serve delay in frame ticks, keeps both scores and declares the winner.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 10,
  parameter int SERVE_DELAY = 60
) (
  input  logic                   board_clk,
  input  logic                   reset,
  input  logic                   start,
  pong_game_ctrl_if.master       bus,
  output state_t                 state,
  output logic [SCORE_W-1:0]     p1_score,
  output logic [SCORE_W-1:0]     p2_score,
  output winner_t                winner
);

  localparam int                   CNT_W      = $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(1);
  localparam logic [SCORE_W-1:0]   SCORE_WIN  = SCORE_W'(WIN_SCORE);

  logic start_s;
  logic start_rise;

  start_sync u_start_sync (
    .board_clk  (board_clk),
    .reset      (reset),
    .in_async   (start),
    .start_s    (start_s),
    .start_rise (start_rise)
  );

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               serve_q, serve_d;
  logic               dir_q, dir_d;
  state_t             state_d;
  winner_t            winner_d;
  logic [SCORE_W-1:0] p1_d, p2_d;
  logic [SCORE_W-1:0] p1_inc, p2_inc;

  assign bus.ball_run  = run_q;
  assign bus.serve     = serve_q;
  assign bus.serve_dir = dir_q;

  // Register every output so nothing combinational reaches the pins.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state    <= QI;
      p1_score <= '0;
      p2_score <= '0;
      winner   <= WIN_NONE;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      serve_q  <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state    <= state_d;
      p1_score <= p1_d;
      p2_score <= p2_d;
      winner   <= winner_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      serve_q  <= serve_d;
      dir_q    <= dir_d;
    end
  end

  // Next-state, scoring and serve timing for the match.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state;
    p1_d     = p1_score;
    p2_d     = p2_score;
    winner_d = winner;
    cnt_d    = cnt_q;
    run_d    = run_q;
    serve_d  = 1'b0;
    dir_d    = dir_q;
    p1_inc   = p1_score + 1'b1;
    p2_inc   = p2_score + 1'b1;

    case (state)
      QI: begin
        p1_d     = '0;
        p2_d     = '0;
        winner_d = WIN_NONE;
        run_d    = 1'b0;
        if (start_rise) begin
          state_d = QGAME_1;
          cnt_d   = CNT_RELOAD;
        end
      end

      QGAME_1, QGAME_2: begin
        if (!start_s) begin
          // Switch dropped mid-match: abort, wins over misses and ticks.
          state_d  = QI;
          p1_d     = '0;
          p2_d     = '0;
          winner_d = WIN_NONE;
          run_d    = 1'b0;
        end else if (run_q) begin
          if (bus.p1_miss && bus.p2_miss) begin
            // Simultaneous misses: nobody scores, same server re-serves.
            run_d = 1'b0;
            cnt_d = CNT_RELOAD;
          end else if (bus.p1_miss) begin
            p2_d  = p2_inc;
            run_d = 1'b0;
            cnt_d = CNT_RELOAD;
            if (p2_inc == SCORE_WIN) begin
              state_d  = QDONE;
              winner_d = WIN_P2;
            end else begin
              state_d = QGAME_2;
            end
          end else if (bus.p2_miss) begin
            p1_d  = p1_inc;
            run_d = 1'b0;
            cnt_d = CNT_RELOAD;
            if (p1_inc == SCORE_WIN) begin
              state_d  = QDONE;
              winner_d = WIN_P1;
            end else begin
              state_d = QGAME_1;
            end
          end
        end else if (bus.tick && (cnt_q != '0)) begin
          // Serve wait: the tick that reaches zero launches the ball.
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            serve_d = 1'b1;
            run_d   = 1'b1;
            dir_d   = (state == QGAME_2);
          end
        end
      end

      QDONE: begin
        run_d = 1'b0;
        if (!start_s) begin
          state_d  = QI;
          p1_d     = '0;
          p2_d     = '0;
          winner_d = WIN_NONE;
        end
      end

      default: begin
        state_d = QI;
      end
    endcase
  end

endmodule
